// File: rtl/nf10_upb_reset_seq_pkg.sv
// Shared types and constants for the NF10 UPB reset sequencer.
package nf10_upb_reset_seq_pkg;

    typedef enum logic [2:0] {
        RST_MMCM  = 3'd0,
        WAIT_LOCK = 3'd1,
        RST_IDLY  = 3'd2,
        WAIT_RDY  = 3'd3,
        WAIT_DCI  = 3'd4,
        STABLE    = 3'd5,
        RUN       = 3'd6
    } seq_state_e;

    localparam logic [7:0] RETRY_SAT = 8'hFF;

    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/nf10_upb_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit; clears to 0.
module nf10_upb_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nf10_upb_reset_sequencer.sv
// MMCM / IODELAYCTRL / DCI bring-up sequencer owning the system reset.
// NF10_UPB_RESET_SEQ_STATUS_EN adds state_code and lock_loss_count outputs.
//   state     | meaning
//   RST_MMCM  | hold mmcm_rst for mmcm_rst_cycles
//   WAIT_LOCK | wait for MMCM lock, timeout retries MMCM reset
//   RST_IDLY  | hold idelayctrl_rst for idelay_rst_cycles
//   WAIT_RDY  | wait for IODELAYCTRL ready, timeout retries IDELAY reset
//   WAIT_DCI  | wait for DCI calibration, timeout retries MMCM reset
//   STABLE    | all goods high for stable_cycles in a row
//   RUN       | system reset released
module nf10_upb_reset_sequencer
    import nf10_upb_reset_seq_pkg::*;
#(
    parameter int mmcm_rst_cycles     = 16,
    parameter int lock_timeout_cycles = 100000,
    parameter int idelay_rst_cycles   = 8,
    parameter int stable_cycles       = 1024,
    parameter int use_iodelay_control = 1,
    parameter int wait_for_dci_locked = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mmcm_locked,
    input  logic        idelayctrl_rdy,
    input  logic        dci_locked,
    output logic        mmcm_rst,
    output logic        idelayctrl_rst,
    output logic        reset_out,
    output logic        reset_n_out,
    output logic [7:0]  retry_count,
    output logic        seq_done
`ifdef NF10_UPB_RESET_SEQ_STATUS_EN
    ,
    output logic [2:0]  state_code,
    output logic [15:0] lock_loss_count
`endif
);

    localparam int CW = cnt_width(mmcm_rst_cycles, lock_timeout_cycles,
                                  idelay_rst_cycles, stable_cycles);
    localparam logic [CW-1:0] MMCM_LAST   = CW'(mmcm_rst_cycles - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(lock_timeout_cycles - 1);
    localparam logic [CW-1:0] IDLY_LAST   = CW'(idelay_rst_cycles - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(stable_cycles - 1);

    localparam seq_state_e AFTER_RDY  = (wait_for_dci_locked != 0) ? WAIT_DCI : STABLE;
    localparam seq_state_e AFTER_LOCK = (use_iodelay_control != 0) ? RST_IDLY : AFTER_RDY;

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mmcm_rst_q, idly_rst_q, reset_q, reset_n_q, seq_done_q;
    logic [7:0]    retry_q;
    logic          retry_inc;
    logic          lock_s, rdy_s, dci_s;
    logic          rdy_ok, dci_ok;

    nf10_upb_sync2 u_sync_lock (.clk_i(clk), .rst_i(reset), .d_i(mmcm_locked),    .q_o(lock_s));
    nf10_upb_sync2 u_sync_rdy  (.clk_i(clk), .rst_i(reset), .d_i(idelayctrl_rdy), .q_o(rdy_s));
    nf10_upb_sync2 u_sync_dci  (.clk_i(clk), .rst_i(reset), .d_i(dci_locked),     .q_o(dci_s));

    // Disabled resources read as permanently good.
    assign rdy_ok = (use_iodelay_control != 0) ? rdy_s : 1'b1;
    assign dci_ok = (wait_for_dci_locked != 0) ? dci_s : 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retry_inc = 1'b0;
        case (state_q)
            RST_MMCM:  if (cnt_q == MMCM_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) state_d = AFTER_LOCK;
                else if (cnt_q == TO_LAST) begin
                    state_d   = RST_MMCM;
                    retry_inc = 1'b1;
                end
            end
            RST_IDLY:  if (cnt_q == IDLY_LAST) state_d = WAIT_RDY;
            WAIT_RDY: begin
                if (rdy_ok) state_d = AFTER_RDY;
                else if (cnt_q == TO_LAST) begin
                    state_d   = RST_IDLY;
                    retry_inc = 1'b1;
                end
            end
            WAIT_DCI: begin
                if (dci_ok) state_d = STABLE;
                else if (cnt_q == TO_LAST) begin
                    state_d   = RST_MMCM;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d   = RST_MMCM;
                    retry_inc = 1'b1;
                end else if (!(rdy_ok && dci_ok)) cnt_d = '0;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s)      state_d = RST_MMCM;
                else if (!rdy_ok) state_d = RST_IDLY;
                else if (!dci_ok) state_d = WAIT_DCI;
                retry_inc = (state_d != RUN);
            end
            default: state_d = RST_MMCM;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_MMCM;
            cnt_q      <= '0;
            mmcm_rst_q <= 1'b1;
            idly_rst_q <= 1'b1;
            reset_q    <= 1'b1;
            reset_n_q  <= 1'b0;
            seq_done_q <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mmcm_rst_q <= (state_d == RST_MMCM);
            idly_rst_q <= (state_d inside {RST_MMCM, WAIT_LOCK, RST_IDLY});
            reset_q    <= (state_d != RUN);
            reset_n_q  <= (state_d == RUN);
            seq_done_q <= (state_d == RUN);
            if (retry_inc && (retry_q != RETRY_SAT)) retry_q <= retry_q + 8'd1;
        end
    end

    assign mmcm_rst       = mmcm_rst_q;
    assign idelayctrl_rst = idly_rst_q;
    assign reset_out      = reset_q;
    assign reset_n_out    = reset_n_q;
    assign retry_count    = retry_q;
    assign seq_done       = seq_done_q;

`ifdef NF10_UPB_RESET_SEQ_STATUS_EN
    logic [15:0] loss_q;
    logic        loss_inc;

    assign loss_inc = (state_q == RUN) && (state_d != RUN);

    always_ff @(posedge clk) begin
        if (reset)                              loss_q <= '0;
        else if (loss_inc && (loss_q != 16'hFFFF)) loss_q <= loss_q + 16'd1;
    end

    assign state_code      = state_q;
    assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_nf10_upb_reset_sequencer.sv
// Directed bench for nf10_upb_reset_sequencer: full-feature and reduced-feature instances.
module tb_nf10_upb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, lock, rdy, dci;
    logic       mmcm_rst, idly_rst, rst_out, rst_n_out, done;
    logic [7:0] retry;

    logic       rst2, lock2, rdy2, dci2;
    logic       mmcm_rst2, idly_rst2, rst_out2, rst_n_out2, done2;
    logic [7:0] retry2;

`ifdef NF10_UPB_RESET_SEQ_STATUS_EN
    logic [2:0]  state_code, state_code2;
    logic [15:0] loss_cnt, loss_cnt2;
`endif

    nf10_upb_reset_sequencer #(
        .mmcm_rst_cycles(4), .lock_timeout_cycles(20), .idelay_rst_cycles(6),
        .stable_cycles(10), .use_iodelay_control(1), .wait_for_dci_locked(1)
    ) dut (
        .clk(clk), .reset(rst), .mmcm_locked(lock), .idelayctrl_rdy(rdy), .dci_locked(dci),
        .mmcm_rst(mmcm_rst), .idelayctrl_rst(idly_rst), .reset_out(rst_out),
        .reset_n_out(rst_n_out), .retry_count(retry), .seq_done(done)
`ifdef NF10_UPB_RESET_SEQ_STATUS_EN
        , .state_code(state_code), .lock_loss_count(loss_cnt)
`endif
    );

    nf10_upb_reset_sequencer #(
        .mmcm_rst_cycles(4), .lock_timeout_cycles(20), .idelay_rst_cycles(6),
        .stable_cycles(10), .use_iodelay_control(0), .wait_for_dci_locked(0)
    ) dut2 (
        .clk(clk), .reset(rst2), .mmcm_locked(lock2), .idelayctrl_rdy(rdy2), .dci_locked(dci2),
        .mmcm_rst(mmcm_rst2), .idelayctrl_rst(idly_rst2), .reset_out(rst_out2),
        .reset_n_out(rst_n_out2), .retry_count(retry2), .seq_done(done2)
`ifdef NF10_UPB_RESET_SEQ_STATUS_EN
        , .state_code(state_code2), .lock_loss_count(loss_cnt2)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int   n, r1, r2, w1;
        logic prev, seen_rst;

        rst = 1'b1; lock = 1'b0; rdy = 1'b0; dci = 1'b0;
        rst2 = 1'b1; lock2 = 1'b0; rdy2 = 1'b0; dci2 = 1'b0;
        tick(3);
        chk("rst_mmcm_rst", mmcm_rst, 1);
        chk("rst_idly_rst", idly_rst, 1);
        chk("rst_reset_out", rst_out, 1);
        chk("rst_reset_n_out", rst_n_out, 0);
        chk("rst_retry", retry, 0);
        chk("rst_seq_done", done, 0);

        // Nominal bring-up
        rst = 1'b0;
        n = 0;
        while (mmcm_rst !== 1'b0 && n < 100) begin tick(); n++; end
        chk("t1_mmcm_rst_width", n, 4);
        tick(5);
        lock = 1'b1;
        n = 0;
        while (idly_rst !== 1'b0 && n < 100) begin tick(); n++; end
        chk("t1_idly_release", n, 9);
        rdy = 1'b1;
        tick(3);
        dci = 1'b1;
        n = 0;
        while (rst_out !== 1'b0 && n < 100) begin tick(); n++; end
        chk("t1_release_latency", n, 13);
        chk("t1_reset_n_out", rst_n_out, 1);
        chk("t1_seq_done", done, 1);
        chk("t1_retry", retry, 0);
        chk("t1_mmcm_rst", mmcm_rst, 0);
        chk("t1_idly_rst", idly_rst, 0);

        // One-cycle MMCM lock glitch in RUN
        lock = 1'b0;
        tick();
        lock = 1'b1;
        tick();
        chk("t3_reset_out_pre", rst_out, 0);
        tick();
        chk("t3_reset_out", rst_out, 1);
        chk("t3_mmcm_rst", mmcm_rst, 1);
        chk("t3_retry", retry, 1);
        chk("t3_seq_done", done, 0);
        n = 0;
        while (rst_out !== 1'b0 && n < 200) begin tick(); n++; end
        chk("t3_recovery_cycles", n, 23);
        chk("t3_retry_after", retry, 1);

        // DCI loss in RUN
        dci = 1'b0;
        tick(3);
        chk("t4_reset_out", rst_out, 1);
        chk("t4_mmcm_rst", mmcm_rst, 0);
        chk("t4_idly_rst", idly_rst, 0);
        chk("t4_retry", retry, 2);
        chk("t4_seq_done", done, 0);
`ifdef NF10_UPB_RESET_SEQ_STATUS_EN
        chk("t4_state_code", state_code, 4);
        chk("t4_loss_count", loss_cnt, 2);
`endif
        tick(2);
        dci = 1'b1;
        n = 0;
        seen_rst = 1'b0;
        while (rst_out !== 1'b0 && n < 200) begin
            tick();
            n++;
            seen_rst = seen_rst | mmcm_rst | idly_rst;
        end
        chk("t4_recovery_cycles", n, 13);
        chk("t4_no_resource_reset", seen_rst, 0);
        chk("t4_retry_after", retry, 2);

        // MMCM lock absent for 50 cycles
        rst = 1'b1; lock = 1'b0;
        tick(2);
        rst = 1'b0;
        prev = 1'b1; r1 = 0; r2 = 0; w1 = 0;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (mmcm_rst && !prev) begin
                if (r1 == 0) r1 = t;
                else if (r2 == 0) r2 = t;
            end
            if (!mmcm_rst && prev && r1 != 0 && w1 == 0) w1 = t - r1;
            prev = mmcm_rst;
        end
        lock = 1'b1;
        chk("t2_first_retry_pulse", r1, 24);
        chk("t2_pulse_period", r2 - r1, 24);
        chk("t2_pulse_width", w1, 4);
        n = 0;
        while (rst_out !== 1'b0 && n < 200) begin tick(); n++; end
        chk("t2_reset_out", rst_out, 0);
        chk("t2_seq_done", done, 1);
        chk("t2_retry", retry, 2);

        // Retry counter saturation
        rst = 1'b1; lock = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(300 * 24);
        chk("t5_retry_sat", retry, 255);
        tick(48);
        chk("t5_retry_hold", retry, 255);
        chk("t5_reset_out", rst_out, 1);

        // Reduced-feature instance: reset while in STABLE, IDELAY/DCI ignored
        rst2 = 1'b0;
        tick(30);
        chk("t6_retry_pre", retry2, 1);
        lock2 = 1'b1;
        tick(5);
        chk("t6_stable_reset_out", rst_out2, 1);
        chk("t6_stable_idly_rst", idly_rst2, 0);
        chk("t6_stable_mmcm_rst", mmcm_rst2, 0);
        rst2 = 1'b1;
        tick();
        chk("t6_mmcm_rst", mmcm_rst2, 1);
        chk("t6_reset_out", rst_out2, 1);
        chk("t6_reset_n_out", rst_n_out2, 0);
        chk("t6_retry", retry2, 0);
        chk("t6_idly_rst", idly_rst2, 1);
        chk("t6_seq_done", done2, 0);
        rst2 = 1'b0;
        n = 0;
        while (rst_out2 !== 1'b0 && n < 200) begin tick(); n++; end
        chk("t6_bringup_cycles", n, 15);
        chk("t6_seq_done_run", done2, 1);
        chk("t6_retry_run", retry2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
